vga_frame_feeder: RTL and testbench

Feeder end of the VGA command/FIFO interface. On a `start` pulse it raises `` `VGA_PREPARE `` on the shared `command` bus and waits for the screen side to acknowledge with `clear_command`. It then streams one frame of 12-bit pixels from pixel memory into the VGA FIFO, honouring `fifo_full` back-pressure. It sits between the frame store and the VGA FIFO and is the producer that the screen-side consumer waits on.

---
 rtl/vga_frame_feeder_pkg.sv | 20 ++
 rtl/vga_frame_feeder_if.sv | 39 +++
 rtl/vga_frame_feeder_pixel_skid_register.sv | 58 +++++
 rtl/vga_frame_feeder.sv | 133 +++++++++++++
 tb/tb_vga_frame_feeder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_frame_feeder_pkg.sv
// Shared types and command codes for the VGA frame feeder.
// VGA_NOP / VGA_PREPARE carry the same values as the screen side's
// vga_commands.v decoder; this block defines no new codes.
package vga_frame_feeder_pkg;

    localparam int CMD_WIDTH   = 3;
    localparam int PIXEL_WIDTH = 12;

    typedef logic [CMD_WIDTH-1:0]   vga_cmd_t;
    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    localparam vga_cmd_t VGA_NOP     = 3'd0;
    localparam vga_cmd_t VGA_PREPARE = 3'd1;

    // Number of pixels in one frame.
    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/vga_frame_feeder_if.sv
// Command, pixel-memory and VGA-FIFO signals between the feeder (master)
// and the memory/screen side (slave).
interface vga_frame_feeder_if #(
    parameter int ADDRESS_WIDTH = 19
);
    import vga_frame_feeder_pkg::*;

    vga_cmd_t                 command;
    logic                     clear_command;
    logic                     mem_read;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    pixel_t                   mem_data;
    logic                     fifo_full;
    logic                     fifo_write;
    pixel_t                   fifo_data;

    modport master (
        output command,
        output mem_read,
        output mem_address,
        output fifo_write,
        output fifo_data,
        input  clear_command,
        input  mem_data,
        input  fifo_full
    );

    modport slave (
        input  command,
        input  mem_read,
        input  mem_address,
        input  fifo_write,
        input  fifo_data,
        output clear_command,
        output mem_data,
        output fifo_full
    );

endinterface

// File: rtl/vga_frame_feeder_pixel_skid_register.sv
// One-entry skid buffer between pixel memory and the VGA FIFO.
// A read strobe returns data one cycle later; if the FIFO is full when it
// arrives, the pixel is parked here and drained ahead of anything else.
module pixel_skid_register
    import vga_frame_feeder_pkg::*;
(
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   in_valid_i,    // memory read strobe; data follows next cycle
    input  pixel_t in_data_i,     // memory read data, valid one cycle after in_valid_i
    input  logic   full_i,        // downstream cannot accept this cycle
    output logic   out_valid_o,   // write strobe downstream
    output pixel_t out_data_o,
    output logic   hold_valid_o   // a pixel is parked; upstream must stall
);

    logic   return_valid_q, return_valid_d;
    logic   hold_valid_q,   hold_valid_d;
    pixel_t hold_data_q,    hold_data_d;

    // Next-state for the return pipeline and the parked pixel.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        return_valid_d = in_valid_i;
        hold_valid_d   = hold_valid_q;
        hold_data_d    = hold_data_q;
        if (return_valid_q && full_i) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data_i;
        end else if (hold_valid_q && !full_i) begin
            hold_valid_d = 1'b0;
        end
    end

    // Control flops: cleared by reset so in-flight data is discarded.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (reset_i) begin
            return_valid_q <= 1'b0;
            hold_valid_q   <= 1'b0;
        end else begin
            return_valid_q <= return_valid_d;
            hold_valid_q   <= hold_valid_d;
        end
    end

    // Parked pixel data.
    always_ff @(posedge clk_i) begin
        // NOTE: data-only storage is not reset; hold_valid_q qualifies it, so reset only costs routing here.
        hold_data_q <= hold_data_d;
    end

    // The parked pixel is always older than a returning one, so it goes first.
    assign out_valid_o  = (hold_valid_q || return_valid_q) && !full_i;
    assign out_data_o   = hold_valid_q ? hold_data_q : in_data_i;
    assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/vga_frame_feeder.sv
// Feeder end of the VGA command/FIFO link. A start pulse raises VGA_PREPARE
// until the screen side clears it, then one frame of pixels is streamed in
// raster order from pixel memory into the VGA FIFO under fifo_full
// back-pressure. ADDRESS_WIDTH must be able to hold WIDTH*HEIGHT-1.
module vga_frame_feeder
    import vga_frame_feeder_pkg::*;
#(
    parameter int WIDTH         = 640,
    parameter int HEIGHT        = 480,
    parameter int ADDRESS_WIDTH = 19
) (
    input  logic                      vga_clock,
    input  logic                      reset,
    input  logic                      start,
    vga_frame_feeder_if.master        bus,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int PIXELS    = frame_pixels(WIDTH, HEIGHT);
    // One extra bit so the counters can hold PIXELS itself.
    localparam int CNT_WIDTH = ADDRESS_WIDTH + 1;

    typedef logic [CNT_WIDTH-1:0] count_t;

    localparam count_t PIXELS_C = count_t'(PIXELS);
    localparam count_t LAST_C   = count_t'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t   state_q,   state_d;
    vga_cmd_t command_q, command_d;
    count_t   issued_q,  issued_d;
    count_t   written_q, written_d;

    logic   mem_read_c;
    logic   frame_done_c;
    logic   fifo_write_c;
    pixel_t fifo_data_c;
    logic   hold_valid;

    pixel_skid_register u_skid (
        .clk_i        (vga_clock),
        .reset_i      (reset),
        .in_valid_i   (mem_read_c),
        .in_data_i    (bus.mem_data),
        .full_i       (bus.fifo_full),
        .out_valid_o  (fifo_write_c),
        .out_data_o   (fifo_data_c),
        .hold_valid_o (hold_valid)
    );

    // FSM next-state, command register, read issue and frame counters.
    always_comb begin
        state_d      = state_q;
        command_d    = command_q;
        issued_d     = issued_q;
        written_d    = written_q;
        mem_read_c   = 1'b0;
        frame_done_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    command_d = VGA_PREPARE;
                    issued_d  = '0;
                    written_d = '0;
                    state_d   = ISSUE;
                end
            end

            ISSUE: begin
                // Unbounded wait: the screen side decides when it is ready.
                if (bus.clear_command) begin
                    command_d = VGA_NOP;
                    state_d   = STREAM;
                end
            end

            STREAM: begin
                // Never read while a pixel is parked: at most one can be outstanding.
                mem_read_c = !bus.fifo_full && !hold_valid && (issued_q < PIXELS_C);
                if (mem_read_c) begin
                    issued_d = issued_q + count_t'(1);
                end
                if (fifo_write_c) begin
                    written_d = written_q + count_t'(1);
                    if (written_q == LAST_C) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                frame_done_c = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q   <= IDLE;
            command_q <= VGA_NOP;
            issued_q  <= '0;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            command_q <= command_d;
            issued_q  <= issued_d;
            written_q <= written_d;
        end
    end

    assign bus.command     = command_q;
    assign bus.mem_read    = mem_read_c;
    assign bus.mem_address = issued_q[ADDRESS_WIDTH-1:0];
    assign bus.fifo_write  = fifo_write_c;
    assign bus.fifo_data   = fifo_data_c;
    assign busy            = (state_q != IDLE);
    assign frame_done      = frame_done_c;

endmodule

// File: tb/tb_vga_frame_feeder.sv
// Randomised self-checking bench for vga_frame_feeder on a 4x2 frame.
// The reference tracks frame phase, counts of pixels read and written, and
// a queue of pixels that have come back from memory but are not yet in the FIFO.
module tb_vga_frame_feeder;
    import vga_frame_feeder_pkg::*;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int AW    = 3;
    localparam int TOTAL = W * H;
    localparam int BUDGET = 300;

    localparam int P_IDLE   = 0;
    localparam int P_ACK    = 1;
    localparam int P_STREAM = 2;
    localparam int P_DONE   = 3;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic frame_done;

    vga_frame_feeder_if #(.ADDRESS_WIDTH(AW)) bus ();

    vga_frame_feeder #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .vga_clock  (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    pixel_t salt = '0;
    bit     armed = 1'b0;

    // Reference state
    int m_ph     = P_IDLE;
    int m_issued = 0;
    int m_written = 0;
    bit m_ret    = 1'b0;
    int m_ret_a  = 0;
    int parked[$];

    // Memory environment: answers one cycle after a read strobe
    bit env_ret  = 1'b0;
    int env_addr = 0;

    // Observations of the current cycle and per-frame tallies
    bit     o_write;
    bit     o_done;
    pixel_t o_data;
    int     n_writes, n_done, n_reads, n_prepare;
    pixel_t obs[$];

    function automatic pixel_t pixel(input int a);
        return pixel_t'(a) ^ salt;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_counts();
        n_writes  = 0;
        n_done    = 0;
        n_reads   = 0;
        n_prepare = 0;
        obs.delete();
    endtask

    // One clock cycle: drive at the falling edge, compare 1 ns later, advance the reference.
    task automatic step(input bit rst, input bit st, input bit clr, input bit full);
        bit e_write, e_read, consumed, n_ret;
        int e_head, n_a;
        @(negedge clk);
        reset              = rst;
        start              = st;
        bus.clear_command  = clr;
        bus.fifo_full      = full;
        bus.mem_data       = env_ret ? pixel(env_addr) : pixel_t'($urandom);
        #1;
        e_write = (parked.size() > 0 || m_ret) && !full;
        e_head  = (parked.size() > 0) ? parked[0] : m_ret_a;
        e_read  = (m_ph == P_STREAM) && !full && (parked.size() == 0) && (m_issued < TOTAL);
        if (armed) begin
            check("command",    bus.command,    (m_ph == P_ACK) ? VGA_PREPARE : VGA_NOP);
            check("busy",       busy,           m_ph != P_IDLE);
            check("frame_done", frame_done,     m_ph == P_DONE);
            check("mem_read",   bus.mem_read,   e_read);
            check("fifo_write", bus.fifo_write, e_write);
            if (e_read)  check("mem_address", bus.mem_address, m_issued);
            if (e_write) check("fifo_data",   bus.fifo_data,   pixel(e_head));
        end

        o_write = (bus.fifo_write === 1'b1);
        o_done  = (frame_done === 1'b1);
        o_data  = bus.fifo_data;
        if (o_write) begin
            n_writes++;
            obs.push_back(bus.fifo_data);
        end
        if (o_done) n_done++;
        if (bus.mem_read === 1'b1) n_reads++;
        if (bus.command === VGA_PREPARE) n_prepare++;
        env_ret  = (bus.mem_read === 1'b1);
        env_addr = int'(bus.mem_address);

        if (rst) begin
            m_ph      = P_IDLE;
            m_issued  = 0;
            m_written = 0;
            m_ret     = 1'b0;
            parked.delete();
            armed     = 1'b1;
        end else begin
            consumed = 1'b0;
            n_ret    = 1'b0;
            n_a      = 0;
            case (m_ph)
                P_IDLE: if (st) begin
                    m_ph      = P_ACK;
                    m_issued  = 0;
                    m_written = 0;
                end
                P_ACK: if (clr) m_ph = P_STREAM;
                P_STREAM: begin
                    if (e_write) begin
                        if (parked.size() > 0) void'(parked.pop_front());
                        else consumed = 1'b1;
                        m_written++;
                        if (m_written == TOTAL) m_ph = P_DONE;
                    end
                    if (m_ret && !consumed) parked.push_back(m_ret_a);
                    if (e_read) begin
                        n_ret = 1'b1;
                        n_a   = m_issued;
                        m_issued++;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
            m_ret   = n_ret;
            m_ret_a = n_a;
        end
    endtask

    // One frame: start at cycle 0, clear_command at clr_at, stray start at stray_at.
    // mode: 0 never full, 1 full on odd cycles, 2 full for cycles 7..11, 3 random.
    task automatic frame(input int clr_at, input int mode, input int stray_at,
                         output int done_cyc, output int rel_cyc, output pixel_t rel_data);
        bit full;
        reset_counts();
        done_cyc = -1;
        rel_cyc  = -1;
        rel_data = '0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= BUDGET; c++) begin
            case (mode)
                1:       full = (c % 2) == 1;
                2:       full = (c >= 7) && (c <= 11);
                3:       full = ($urandom_range(0, 2) == 0);
                default: full = 1'b0;
            endcase
            step(1'b0, c == stray_at, c == clr_at, full);
            if (mode == 2 && c >= 7 && rel_cyc < 0 && o_write) begin
                rel_cyc  = c;
                rel_data = o_data;
            end
            if (o_done) begin
                done_cyc = c;
                break;
            end
        end
        if (done_cyc < 0) check("frame_timeout", 0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("frame_write_count", n_writes, TOTAL);
        check("frame_done_count",  n_done,   1);
        for (int i = 0; i < TOTAL && i < obs.size(); i++) begin
            check("frame_order", obs[i], pixel(i));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_command",     bus.command,     VGA_NOP);
        check("rst_mem_read",    bus.mem_read,    0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_fifo_write",  bus.fifo_write,  0);
        check("rst_busy",        busy,            0);
        check("rst_frame_done",  frame_done,      0);
    endtask

    initial begin
        int     d, r;
        pixel_t rd;
        reset             = 1'b1;
        start             = 1'b0;
        bus.clear_command = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.mem_data      = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_reset_outputs();

        // Basic frame, mem_data equals address, ack three cycles after start.
        salt = '0;
        frame(3, 0, -1, d, r, rd);
        check("t1_prepare_cycles", n_prepare, 3);
        check("t1_done_cycle",     d,         13);
        check("t1_reads",          n_reads,   TOTAL);

        // Back-pressure exactly when address 2 returns, held five cycles.
        salt = 12'h5a3;
        frame(3, 2, -1, d, r, rd);
        check("t2_release_cycle", r,  12);
        check("t2_release_data",  rd, pixel(2));

        // fifo_full toggling every cycle.
        salt = 12'h0f0;
        frame(3, 1, -1, d, r, rd);

        // Stray start in the middle of streaming.
        salt = 12'h321;
        frame(3, 0, 6, d, r, rd);

        // Reset after three pixels have been written.
        salt = 12'h777;
        reset_counts();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= BUDGET && n_writes < 3; c++) begin
            step(1'b0, 1'b0, c == 3, 1'b0);
        end
        check("t5_writes_before_reset", n_writes, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_reset_outputs();
        salt = 12'h18c;
        frame(2, 0, -1, d, r, rd);

        // No acknowledgement for 1000 cycles.
        reset_counts();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 1000; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        check("t6_reads",    n_reads,   0);
        check("t6_writes",   n_writes,  0);
        check("t6_prepare",  n_prepare, 1000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_reset_outputs();

        // Randomised frames: ack delay, back-pressure, stray starts, idle gaps.
        for (int k = 0; k < 15; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            salt = pixel_t'($urandom);
            frame($urandom_range(1, 6), 3, $urandom_range(1, 25), d, r, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
